// File: rtl/mips32_pkg.sv
// Shared constants for the MIPS32 core and its program loader.
// Holds the loader state encoding and the opcodes both sides agree on.
package mips32_pkg;

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StLoad  = 3'd1,
    StStart = 3'd2,
    StRun   = 3'd3,
    StError = 3'd4
  } state_e;

  localparam logic [5:0]  OP_ADD    = 6'h00;
  localparam logic [5:0]  OP_OR     = 6'h03;
  localparam logic [5:0]  OP_ADDI   = 6'h0a;
  localparam logic [5:0]  OP_HLT    = 6'h3f;
  localparam logic [31:0] HLT_INSTR = {OP_HLT, 26'd0};

endpackage

// File: rtl/mips32_prog_loader_if.sv
// Program-word stream into the loader: valid/ready handshake with an end-of-program marker.
interface mips32_prog_loader_if;
  logic        in_valid;
  logic [31:0] in_data;
  logic        in_last;
  logic        in_ready;

  modport master (output in_valid, output in_data, output in_last, input in_ready);
  modport slave  (input in_valid, input in_data, input in_last, output in_ready);
endinterface

// File: rtl/mips32_prog_loader.sv
// Writes a streamed program into instruction memory, then starts the core at BASE_ADDR
// and waits for it to halt.
module mips32_prog_loader
  import mips32_pkg::*;
#(
  parameter int unsigned ADDR_W      = 10,
  parameter int unsigned MEM_DEPTH   = 1024,
  parameter int unsigned BASE_ADDR   = 0,
  parameter bit          STOP_ON_HLT = 1'b1,
  parameter logic [31:0] HLT_WORD    = HLT_INSTR
) (
  input  logic                clk1,
  input  logic                rst,
  input  logic                load_req,
  mips32_prog_loader_if.slave in_if,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [31:0]         mem_wdata,
  output logic                cpu_hold,
  output logic                cpu_start,
  output logic [31:0]         start_pc,
  input  logic                cpu_halted,
  output logic [ADDR_W:0]     word_count,
  output logic                busy,
  output logic                load_err,
  output logic                done
);

  localparam logic [ADDR_W-1:0] BaseAddr = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(BASE_ADDR + MEM_DEPTH - 1);

  state_e            state_q;
  logic [ADDR_W-1:0] ptr_q;
  logic              mem_we_q, cpu_hold_q, cpu_start_q, load_err_q, done_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [31:0]       mem_wdata_q;
  logic [ADDR_W:0]   word_count_q;
  logic              xfer, term;

  assign in_if.in_ready = (state_q == StLoad);
  assign xfer = in_if.in_valid & in_if.in_ready;
  assign term = in_if.in_last | (STOP_ON_HLT && (in_if.in_data == HLT_WORD));

  always_ff @(posedge clk1) begin
    if (rst) begin
      state_q      <= StIdle;
      ptr_q        <= BaseAddr;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      cpu_hold_q   <= 1'b1;
      cpu_start_q  <= 1'b0;
      load_err_q   <= 1'b0;
      done_q       <= 1'b0;
      word_count_q <= '0;
    end else begin
      mem_we_q    <= 1'b0;
      cpu_start_q <= 1'b0;
      done_q      <= 1'b0;
      unique case (state_q)
        StIdle, StError: begin
          if (load_req) begin
            state_q      <= StLoad;
            ptr_q        <= BaseAddr;
            word_count_q <= '0;
            load_err_q   <= 1'b0;
          end
        end
        StLoad: begin
          if (xfer) begin
            mem_we_q     <= 1'b1;
            mem_addr_q   <= ptr_q;
            mem_wdata_q  <= in_if.in_data;
            word_count_q <= word_count_q + (ADDR_W + 1)'(1);
            if (ptr_q != LastAddr) ptr_q <= ptr_q + ADDR_W'(1);
            // A terminator in the last slot is a normal end, not an overflow.
            if (term) begin
              state_q <= StStart;
            end else if (ptr_q == LastAddr) begin
              state_q    <= StError;
              load_err_q <= 1'b1;
            end
          end
        end
        StStart: begin
          cpu_hold_q  <= 1'b0;
          cpu_start_q <= 1'b1;
          state_q     <= StRun;
        end
        StRun: begin
          // HALTED is still stale from the previous run while cpu_start is high.
          if (cpu_halted && !cpu_start_q) begin
            state_q    <= StIdle;
            cpu_hold_q <= 1'b1;
            done_q     <= 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign busy       = (state_q == StLoad) || (state_q == StStart);
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign cpu_hold   = cpu_hold_q;
  assign cpu_start  = cpu_start_q;
  assign start_pc   = 32'(BASE_ADDR);
  assign word_count = word_count_q;
  assign load_err   = load_err_q;
  assign done       = done_q;

endmodule

// File: tb/tb_mips32_prog_loader.sv
// Directed bench: three loader instances (default, MEM_DEPTH=4, STOP_ON_HLT=0) share stimulus;
// each scenario observes one of them via sel, with a tiny instruction-level core model.
module tb_mips32_prog_loader;
  import mips32_pkg::*;

  logic        clk1 = 1'b0;
  logic        rst = 1'b1;
  logic        load_req = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] in_data = '0;
  logic        in_last = 1'b0;
  logic        cpu_halted = 1'b1;

  logic [2:0]  in_ready, mem_we, cpu_hold, cpu_start, busy, load_err, done;
  logic [9:0]  mem_addr [3];
  logic [31:0] mem_wdata [3];
  logic [31:0] start_pc [3];
  logic [10:0] word_count [3];
  state_e      st [3];

  int          sel = 0;
  int          cyc = 0;
  int          pass_cnt = 0;
  int          total_cnt = 0;
  logic [31:0] imem [1024];
  logic [31:0] regs [32];
  logic [9:0]  wr_addr [$];
  logic [31:0] wr_data [$];
  int          wr_cyc [$];

  localparam logic [31:0] PROG [10] = '{
    32'h2801000a, 32'h28020014, 32'h28030019, 32'h0ce77800, 32'h0ce77800,
    32'h00222000, 32'h0ce77800, 32'h0ce77800, 32'h00832800, 32'hfc000000
  };

  always #5 clk1 = ~clk1;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    mips32_prog_loader_if u_if ();
    assign u_if.in_valid = in_valid;
    assign u_if.in_data  = in_data;
    assign u_if.in_last  = in_last;
    assign in_ready[g]   = u_if.in_ready;

    mips32_prog_loader #(
      .ADDR_W     (10),
      .MEM_DEPTH  ((g == 1) ? 4 : 1024),
      .BASE_ADDR  (0),
      .STOP_ON_HLT((g == 2) ? 1'b0 : 1'b1),
      .HLT_WORD   (32'hfc000000)
    ) u_dut (
      .clk1      (clk1),
      .rst       (rst),
      .load_req  (load_req),
      .in_if     (u_if),
      .mem_we    (mem_we[g]),
      .mem_addr  (mem_addr[g]),
      .mem_wdata (mem_wdata[g]),
      .cpu_hold  (cpu_hold[g]),
      .cpu_start (cpu_start[g]),
      .start_pc  (start_pc[g]),
      .cpu_halted(cpu_halted),
      .word_count(word_count[g]),
      .busy      (busy[g]),
      .load_err  (load_err[g]),
      .done      (done[g])
    );
    assign st[g] = u_dut.state_q;
  end

  // Instruction memory and write log for the observed instance.
  always @(posedge clk1) begin
    cyc <= cyc + 1;
    if (mem_we[sel]) begin
      imem[mem_addr[sel]] <= mem_wdata[sel];
      wr_addr.push_back(mem_addr[sel]);
      wr_data.push_back(mem_wdata[sel]);
      wr_cyc.push_back(cyc);
    end
  end

  task automatic do_reset();
    rst = 1'b1; load_req = 1'b0; in_valid = 1'b0; in_last = 1'b0; cpu_halted = 1'b1;
    @(posedge clk1); #1;
    @(posedge clk1); #1;
    rst = 1'b0;
    wr_addr.delete(); wr_data.delete(); wr_cyc.delete();
  endtask

  task automatic pulse_load_req();
    load_req = 1'b1;
    @(posedge clk1); #1;
    load_req = 1'b0;
  endtask

  // Called just after a rising edge; returns just after the edge that took the word.
  task automatic send_word(input logic [31:0] d, input logic l, output bit ok);
    ok = 1'b0; in_valid = 1'b1; in_data = d; in_last = l;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk1);
      if (in_ready[sel]) ok = 1'b1;
      @(posedge clk1); #1;
      if (ok) break;
    end
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic exec_program();
    logic [31:0] w, pc;
    logic [4:0]  rs, rt, rd;
    for (int i = 0; i < 32; i++) regs[i] = '0;
    pc = start_pc[sel];
    for (int n = 0; n < 64; n++) begin
      w = imem[pc[9:0]]; rs = w[25:21]; rt = w[20:16]; rd = w[15:11];
      if (w[31:26] == OP_HLT) break;
      case (w[31:26])
        OP_ADD:  regs[rd] = regs[rs] + regs[rt];
        OP_OR:   regs[rd] = regs[rs] | regs[rt];
        OP_ADDI: regs[rt] = regs[rs] + {{16{w[15]}}, w[15:0]};
        default: ;
      endcase
      regs[0] = '0;
      pc = pc + 1;
    end
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk1);
    for (int i = 0; i < 3; i++) begin
      total_cnt++;
      if ({cpu_hold[i], mem_we[i], cpu_start[i], busy[i], load_err[i], done[i], in_ready[i]}
          !== 7'b1000000)
        $display("FAIL reset_flags[%0d]: got %b want 1000000", i,
                 {cpu_hold[i], mem_we[i], cpu_start[i], busy[i], load_err[i], done[i], in_ready[i]});
      else pass_cnt++;
      total_cnt++;
      if ({word_count[i], mem_addr[i], mem_wdata[i], start_pc[i]} !== '0 || st[i] !== StIdle)
        $display("FAIL reset_values[%0d]: cnt=%0d addr=%0d wdata=%h pc=%h st=%0d want zeros/idle",
                 i, word_count[i], mem_addr[i], mem_wdata[i], start_pc[i], st[i]);
      else pass_cnt++;
    end
  endtask

  task automatic test_program();
    bit ok, all_ok, hold_at_done;
    int bad, ndone;
    sel = 0; do_reset();
    pulse_load_req();
    all_ok = 1'b1;
    for (int k = 0; k < 10; k++) begin
      send_word(PROG[k], 1'b0, ok);
      all_ok &= ok;
    end
    total_cnt++;
    if (!all_ok) $display("FAIL prog_accept: some word not accepted, want all 10 accepted");
    else pass_cnt++;
    @(negedge clk1);
    total_cnt++;
    if (st[0] !== StStart || in_ready[0] !== 1'b0 || mem_we[0] !== 1'b1 || mem_addr[0] !== 10'd9)
      $display("FAIL prog_start_cycle: st=%0d rdy=%b we=%b addr=%0d want 2/0/1/9",
               st[0], in_ready[0], mem_we[0], mem_addr[0]);
    else pass_cnt++;
    @(posedge clk1); #1;
    @(negedge clk1);
    total_cnt++;
    if (cpu_start[0] !== 1'b1 || cpu_hold[0] !== 1'b0 || mem_we[0] !== 1'b0 ||
        word_count[0] !== 11'd10)
      $display("FAIL prog_cpu_start: start=%b hold=%b we=%b cnt=%0d want 1/0/0/10",
               cpu_start[0], cpu_hold[0], mem_we[0], word_count[0]);
    else pass_cnt++;
    bad = 0;
    if (wr_addr.size() != 10) bad = 99;
    else
      for (int k = 0; k < 10; k++)
        if (wr_addr[k] !== 10'(k) || wr_data[k] !== PROG[k] || wr_cyc[k] != wr_cyc[0] + k) bad++;
    total_cnt++;
    if (bad != 0) $display("FAIL prog_writes: %0d bad (n=%0d) want 10 consecutive writes 0..9",
                           bad, wr_addr.size());
    else pass_cnt++;
    @(posedge clk1); #1;
    cpu_halted = 1'b0;
    exec_program();
    @(negedge clk1);
    total_cnt++;
    if (st[0] !== StRun || cpu_hold[0] !== 1'b0 || done[0] !== 1'b0)
      $display("FAIL prog_halted_ignored: st=%0d hold=%b done=%b want 3/0/0",
               st[0], cpu_hold[0], done[0]);
    else pass_cnt++;
    repeat (4) @(posedge clk1);
    #1 cpu_halted = 1'b1;
    ndone = 0; hold_at_done = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk1);
      if (done[0]) begin
        ndone++;
        hold_at_done = cpu_hold[0] && (st[0] == StIdle);
      end
    end
    total_cnt++;
    if (ndone != 1 || !hold_at_done)
      $display("FAIL prog_done: pulses=%0d hold_idle=%b want 1/1", ndone, hold_at_done);
    else pass_cnt++;
    total_cnt++;
    if (regs[4] !== 32'd30 || regs[5] !== 32'd55)
      $display("FAIL prog_result: R4=%0d R5=%0d want 30/55", regs[4], regs[5]);
    else pass_cnt++;
  endtask

  task automatic test_toggle_valid();
    bit ok, all_ok;
    int bad;
    logic [31:0] d [3];
    d[0] = 32'h11111111; d[1] = 32'h22222222; d[2] = 32'h33333333;
    sel = 0; do_reset();
    pulse_load_req();
    all_ok = 1'b1;
    for (int k = 0; k < 3; k++) begin
      send_word(d[k], (k == 2), ok);
      all_ok &= ok;
      if (k < 2) begin
        @(posedge clk1); #1;
      end
    end
    @(negedge clk1);
    @(posedge clk1); #1;
    @(negedge clk1);
    bad = 0;
    if (wr_addr.size() != 3) bad = 99;
    else
      for (int k = 0; k < 3; k++) if (wr_addr[k] !== 10'(k) || wr_data[k] !== d[k]) bad++;
    total_cnt++;
    if (bad != 0 || !all_ok)
      $display("FAIL toggle_writes: %0d bad (n=%0d ok=%b) want 3 writes at 0,1,2",
               bad, wr_addr.size(), all_ok);
    else pass_cnt++;
    total_cnt++;
    if (word_count[0] !== 11'd3 || cpu_start[0] !== 1'b1)
      $display("FAIL toggle_count: cnt=%0d start=%b want 3/1", word_count[0], cpu_start[0]);
    else pass_cnt++;
  endtask

  task automatic test_overflow();
    bit ok, all_ok;
    int bad;
    sel = 1; do_reset();
    pulse_load_req();
    all_ok = 1'b1;
    for (int k = 0; k < 4; k++) begin
      send_word(32'h100 + k, 1'b0, ok);
      all_ok &= ok;
    end
    in_valid = 1'b1; in_data = 32'h00000555;
    @(negedge clk1);
    total_cnt++;
    if (!all_ok || st[1] !== StError || in_ready[1] !== 1'b0 || load_err[1] !== 1'b1 ||
        cpu_hold[1] !== 1'b1 || word_count[1] !== 11'd4)
      $display("FAIL ovf_error: ok=%b st=%0d rdy=%b err=%b hold=%b cnt=%0d want 1/4/0/1/1/4",
               all_ok, st[1], in_ready[1], load_err[1], cpu_hold[1], word_count[1]);
    else pass_cnt++;
    repeat (3) @(posedge clk1);
    #1;
    @(negedge clk1);
    bad = 0;
    if (wr_addr.size() != 4) bad = 99;
    else for (int k = 0; k < 4; k++) if (wr_addr[k] !== 10'(k)) bad++;
    total_cnt++;
    if (bad != 0 || in_ready[1] !== 1'b0 || mem_we[1] !== 1'b0)
      $display("FAIL ovf_writes: bad=%0d n=%0d rdy=%b we=%b want 4 writes, 5th held",
               bad, wr_addr.size(), in_ready[1], mem_we[1]);
    else pass_cnt++;
    pulse_load_req();
    @(negedge clk1);
    total_cnt++;
    if (load_err[1] !== 1'b0 || st[1] !== StLoad || word_count[1] !== 11'd0 || in_ready[1] !== 1'b1)
      $display("FAIL ovf_reload: err=%b st=%0d cnt=%0d rdy=%b want 0/1/0/1",
               load_err[1], st[1], word_count[1], in_ready[1]);
    else pass_cnt++;
    @(posedge clk1); #1;
    in_valid = 1'b0;
    @(negedge clk1);
    total_cnt++;
    if (mem_we[1] !== 1'b1 || mem_addr[1] !== 10'd0 || mem_wdata[1] !== 32'h00000555)
      $display("FAIL ovf_held_word: we=%b addr=%0d data=%h want 1/0/00000555",
               mem_we[1], mem_addr[1], mem_wdata[1]);
    else pass_cnt++;
  endtask

  task automatic test_no_hlt_stop();
    bit ok1, ok2;
    sel = 2; do_reset();
    pulse_load_req();
    send_word(32'hfc000000, 1'b0, ok1);
    @(negedge clk1);
    total_cnt++;
    if (!ok1 || st[2] !== StLoad || in_ready[2] !== 1'b1)
      $display("FAIL nohlt_continue: ok=%b st=%0d rdy=%b want 1/1/1", ok1, st[2], in_ready[2]);
    else pass_cnt++;
    @(posedge clk1); #1;
    send_word(32'h00222000, 1'b1, ok2);
    @(negedge clk1);
    total_cnt++;
    if (!ok2 || st[2] !== StStart || mem_addr[2] !== 10'd1 || mem_wdata[2] !== 32'h00222000)
      $display("FAIL nohlt_start: ok=%b st=%0d addr=%0d data=%h want 1/2/1/00222000",
               ok2, st[2], mem_addr[2], mem_wdata[2]);
    else pass_cnt++;
    @(posedge clk1); #1;
    @(negedge clk1);
    total_cnt++;
    if (cpu_start[2] !== 1'b1 || word_count[2] !== 11'd2 || wr_addr.size() != 2)
      $display("FAIL nohlt_writes: start=%b cnt=%0d n=%0d want 1/2/2",
               cpu_start[2], word_count[2], wr_addr.size());
    else pass_cnt++;
  endtask

  task automatic test_reset_mid_load();
    bit ok;
    sel = 0; do_reset();
    pulse_load_req();
    send_word(32'haaaa0001, 1'b0, ok);
    send_word(32'haaaa0002, 1'b0, ok);
    in_valid = 1'b1; in_data = 32'haaaa0003; rst = 1'b1;
    @(posedge clk1); #1;
    rst = 1'b0; in_valid = 1'b0;
    @(negedge clk1);
    total_cnt++;
    if ({cpu_hold[0], mem_we[0], cpu_start[0], busy[0], load_err[0], done[0], in_ready[0]}
        !== 7'b1000000 || st[0] !== StIdle)
      $display("FAIL midrst_flags: got %b st=%0d want 1000000/0",
               {cpu_hold[0], mem_we[0], cpu_start[0], busy[0], load_err[0], done[0], in_ready[0]},
               st[0]);
    else pass_cnt++;
    total_cnt++;
    if ({word_count[0], mem_addr[0], mem_wdata[0]} !== '0)
      $display("FAIL midrst_values: cnt=%0d addr=%0d data=%h want zeros",
               word_count[0], mem_addr[0], mem_wdata[0]);
    else pass_cnt++;
    @(posedge clk1); #1;
    pulse_load_req();
    send_word(32'hbbbb0001, 1'b1, ok);
    @(negedge clk1);
    total_cnt++;
    if (!ok || mem_we[0] !== 1'b1 || mem_addr[0] !== 10'd0 || word_count[0] !== 11'd1)
      $display("FAIL midrst_restart: ok=%b we=%b addr=%0d cnt=%0d want 1/1/0/1",
               ok, mem_we[0], mem_addr[0], word_count[0]);
    else pass_cnt++;
  endtask

  task automatic test_load_req_held();
    bit ok, all_ok, seen_done;
    sel = 0; do_reset();
    load_req = 1'b1;
    @(posedge clk1); #1;
    all_ok = 1'b1;
    for (int k = 0; k < 3; k++) begin
      send_word(32'h0c000000 + k, (k == 2), ok);
      all_ok &= ok;
    end
    @(posedge clk1); #1;
    cpu_halted = 1'b0;
    repeat (4) @(posedge clk1);
    @(negedge clk1);
    total_cnt++;
    if (!all_ok || st[0] !== StRun || cpu_hold[0] !== 1'b0 || word_count[0] !== 11'd3 ||
        wr_addr.size() != 3)
      $display("FAIL reqheld_run: ok=%b st=%0d hold=%b cnt=%0d n=%0d want 1/3/0/3/3",
               all_ok, st[0], cpu_hold[0], word_count[0], wr_addr.size());
    else pass_cnt++;
    total_cnt++;
    if (wr_addr.size() != 3 || wr_addr[2] !== 10'd2)
      $display("FAIL reqheld_addr: n=%0d want last write at 2", wr_addr.size());
    else pass_cnt++;
    @(posedge clk1); #1;
    load_req = 1'b0; cpu_halted = 1'b1;
    seen_done = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk1);
      if (done[0]) seen_done = 1'b1;
    end
    total_cnt++;
    if (!seen_done || st[0] !== StIdle)
      $display("FAIL reqheld_done: done=%b st=%0d want 1/0", seen_done, st[0]);
    else pass_cnt++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_program();
    test_toggle_valid();
    test_overflow();
    test_no_hlt_stop();
    test_reset_mid_load();
    test_load_req_held();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
